// File: rtl/ttl_xor_accumulator.sv
// Clocked XOR checksum engine: folds a frame of Len words into Acc, in plain or
// rotate-left-then-XOR mode, with a valid/ready handshake and held result.
module ttl_xor_accumulator #(
   parameter int WIDTH       = 8,
   parameter int COUNT_WIDTH = 4,
   parameter int DELAY_RISE  = 0,
   parameter int DELAY_FALL  = 0
) (
   input  logic                   Clk,
   input  logic                   Clear_bar,
   input  logic                   Start,
   input  logic                   Abort,
   input  logic                   Mode,
   input  logic [COUNT_WIDTH-1:0] Len,
   input  logic [WIDTH-1:0]       D,
   input  logic                   Valid,
   output logic                   Ready,
   output logic                   Done,
   output logic [WIDTH-1:0]       Acc,
   output logic                   Parity,
   output logic [COUNT_WIDTH-1:0] Count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state_reg, state_next;
   logic [WIDTH-1:0]       acc_reg, acc_next;
   logic [COUNT_WIDTH-1:0] count_reg, count_next;
   logic [COUNT_WIDTH-1:0] len_reg, len_next;
   logic                   mode_reg, mode_next;
   logic [WIDTH-1:0]       acc_rot;
   logic [COUNT_WIDTH-1:0] count_inc;

   assign acc_rot   = {acc_reg[WIDTH-2:0], acc_reg[WIDTH-1]};
   assign count_inc = count_reg + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

   always_ff @(posedge Clk or negedge Clear_bar) begin
      if (!Clear_bar) begin
         state_reg <= IDLE;
         acc_reg   <= '0;
         count_reg <= '0;
         len_reg   <= '0;
         mode_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         count_reg <= count_next;
         len_reg   <= len_next;
         mode_reg  <= mode_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      count_next = count_reg;
      len_next   = len_reg;
      mode_next  = mode_reg;
      // Abort takes priority over every other input, including Start.
      if (Abort) begin
         state_next = IDLE;
         acc_next   = '0;
         count_next = '0;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               if (Start) begin
                  len_next   = Len;
                  mode_next  = Mode;
                  acc_next   = '0;
                  count_next = '0;
                  state_next = (Len == '0) ? DONE : ACC;
               end
            end
            ACC: begin
               if (Valid) begin
                  acc_next   = (mode_reg ? acc_rot : acc_reg) ^ D;
                  count_next = count_inc;
                  if (count_inc == len_reg) begin
                     state_next = DONE;
                  end
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // Outputs depend on registered state only; the delays model TTL output edges.
   assign #(DELAY_RISE, DELAY_FALL) Ready  = (state_reg == ACC);
   assign #(DELAY_RISE, DELAY_FALL) Done   = (state_reg == DONE);
   assign #(DELAY_RISE, DELAY_FALL) Acc    = acc_reg;
   assign #(DELAY_RISE, DELAY_FALL) Parity = ^acc_reg;
   assign #(DELAY_RISE, DELAY_FALL) Count  = count_reg;

endmodule

// File: tb/tb_ttl_xor_accumulator.sv
// Directed bench for ttl_xor_accumulator: linear steps with hand-computed
// expectations checked by immediate assertions.
module tb_ttl_xor_accumulator;

   logic       Clk = 1'b0;
   logic       Clear_bar;
   logic       Start;
   logic       Abort;
   logic       Mode;
   logic [3:0] Len;
   logic [7:0] D;
   logic       Valid;
   logic       Ready;
   logic       Done;
   logic [7:0] Acc;
   logic       Parity;
   logic [3:0] Count;

   int checks = 0;
   int errors = 0;

   ttl_xor_accumulator #(
      .WIDTH(8),
      .COUNT_WIDTH(4),
      .DELAY_RISE(0),
      .DELAY_FALL(0)
   ) dut (
      .Clk(Clk),
      .Clear_bar(Clear_bar),
      .Start(Start),
      .Abort(Abort),
      .Mode(Mode),
      .Len(Len),
      .D(D),
      .Valid(Valid),
      .Ready(Ready),
      .Done(Done),
      .Acc(Acc),
      .Parity(Parity),
      .Count(Count)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic r, input logic d,
                            input logic [7:0] a, input logic p, input logic [3:0] c);
      check({tag, ".ready"},  {31'd0, Ready},  {31'd0, r});
      check({tag, ".done"},   {31'd0, Done},   {31'd0, d});
      check({tag, ".acc"},    {24'd0, Acc},    {24'd0, a});
      check({tag, ".parity"}, {31'd0, Parity}, {31'd0, p});
      check({tag, ".count"},  {28'd0, Count},  {28'd0, c});
      $display("step %-16s ready=%0d done=%0d acc=0x%02h parity=%0d count=%0d",
               tag, Ready, Done, Acc, Parity, Count);
   endtask

   initial begin
      Clear_bar = 1'b0;
      Start = 1'b0; Abort = 1'b0; Mode = 1'b0; Len = 4'd0; D = 8'h00; Valid = 1'b0;
      #2;
      check_all("reset", 0, 0, 8'h00, 0, 4'd0);
      step();
      check_all("reset_edge", 0, 0, 8'h00, 0, 4'd0);
      Clear_bar = 1'b1;
      step();

      // Plain mode, Len=3, back-to-back beats.
      Start = 1'b1; Mode = 1'b0; Len = 4'd3;
      step();
      Start = 1'b0;
      check_all("plain_start", 1, 0, 8'h00, 0, 4'd0);
      Valid = 1'b1; D = 8'h0F;
      step();
      check_all("plain_b1", 1, 0, 8'h0F, 0, 4'd1);
      D = 8'hF0;
      step();
      check_all("plain_b2", 1, 0, 8'hFF, 0, 4'd2);
      D = 8'hAA;
      step();
      check_all("plain_b3", 0, 1, 8'h55, 0, 4'd3);
      D = 8'h33;
      step();
      Valid = 1'b0;
      check_all("done_valid", 0, 1, 8'h55, 0, 4'd3);

      // Rotate mode, Len=2, started straight from DONE.
      Start = 1'b1; Mode = 1'b1; Len = 4'd2;
      step();
      Start = 1'b0;
      check_all("rot_start", 1, 0, 8'h00, 0, 4'd0);
      Valid = 1'b1; D = 8'h81;
      step();
      check_all("rot_b1", 1, 0, 8'h81, 0, 4'd1);
      D = 8'h01;
      step();
      Valid = 1'b0;
      check_all("rot_b2", 0, 1, 8'h02, 1, 4'd2);

      // Len=0 goes straight to DONE.
      Start = 1'b1; Mode = 1'b0; Len = 4'd0;
      step();
      Start = 1'b0;
      check_all("len0", 0, 1, 8'h00, 0, 4'd0);

      // Abort with Start in DONE: Abort wins, back to IDLE.
      Start = 1'b1; Abort = 1'b1; Len = 4'd2;
      step();
      Start = 1'b0; Abort = 1'b0;
      check_all("abort_start", 0, 0, 8'h00, 0, 4'd0);
      Valid = 1'b1; D = 8'hFF;
      step();
      Valid = 1'b0;
      check_all("idle_valid", 0, 0, 8'h00, 0, 4'd0);

      // Stall between beats; Len/Mode changes mid-frame must be ignored.
      Start = 1'b1; Mode = 1'b0; Len = 4'd2;
      step();
      Start = 1'b0;
      Valid = 1'b1; D = 8'h12;
      step();
      check_all("stall_b1", 1, 0, 8'h12, 0, 4'd1);
      Valid = 1'b0; Mode = 1'b1; Len = 4'd1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_all("stall_hold", 1, 0, 8'h12, 0, 4'd1);
      end
      Valid = 1'b1; D = 8'h34;
      step();
      Valid = 1'b0;
      check_all("stall_b2", 0, 1, 8'h26, 1, 4'd2);

      // Restart from DONE with no dead cycle.
      Start = 1'b1; Mode = 1'b0; Len = 4'd1;
      step();
      Start = 1'b0;
      Valid = 1'b1; D = 8'h5A;
      step();
      Valid = 1'b0;
      check_all("rs_f1", 0, 1, 8'h5A, 0, 4'd1);
      Start = 1'b1; Len = 4'd1;
      step();
      Start = 1'b0;
      check_all("rs_start", 1, 0, 8'h00, 0, 4'd0);
      Valid = 1'b1; D = 8'h0F;
      step();
      Valid = 1'b0;
      check_all("rs_f2", 0, 1, 8'h0F, 0, 4'd1);

      // Asynchronous clear mid-frame, then Start held low-reset must not be honoured.
      Start = 1'b1; Len = 4'd4;
      step();
      Start = 1'b0;
      Valid = 1'b1; D = 8'hFF;
      step();
      Valid = 1'b0;
      check_all("async_b1", 1, 0, 8'hFF, 0, 4'd1);
      #2;
      Clear_bar = 1'b0;
      #1;
      check_all("async_clr", 0, 0, 8'h00, 0, 4'd0);
      Start = 1'b1; Len = 4'd2;
      step();
      check_all("clr_start", 0, 0, 8'h00, 0, 4'd0);
      Clear_bar = 1'b1;
      step();
      Start = 1'b0;
      check_all("post_clr", 1, 0, 8'h00, 0, 4'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
